load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage between execute and the MMU data port. Accepts one load/store per transaction.
//  Aligns store data and generates write strobes. Issues one word-aligned memreq on the MMU mem port.
//  Extracts and sign/zero-extends load data from memresp. Reports misalignment/illegal-op exceptions to writeback.
// PARAMETERS
//  TAG_W           5     width of the destination-register tag carried through to writeback
//  TIMEOUT_CYCLES  1024  response watchdog limit (only with LSU_TIMEOUT_EN)
// PORTS
//  clk                  in   1        clock, all state on posedge
//  rst                  in   1        synchronous reset, active-high
//  req_valid            in   1        execute presents an operation
//  req_ready            out  1        1 only in IDLE
//  req_op               in   4        lsu_op_t: LB LH LW LBU LHU SB SH SW
//  req_addr             in   32       byte address
//  req_wdata            in   32       store data, right-justified
//  req_tag              in   TAG_W    destination tag
//  mem_request_enable   out  1        one-cycle request pulse to MMU
//  mem_request          out  memreq   {mode, addr, wstrb, wdata} to MMU
//  mem_response_enable  in   1        MMU completion pulse
//  mem_response         in   memresp  {data} from MMU
//  done_valid           out  1        one-cycle completion pulse
//  done_data            out  32       extended load value; 0 for stores/exceptions
//  done_tag             out  TAG_W    tag of the completed op
//  done_exc             out  1        exception flag
//  done_cause           out  4        RISC-V cause: 2 illegal, 4/6 ld/st misaligned, 5/7 ld/st access fault
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0 except req_ready=1. Reset mid-transaction abandons the op, no done_valid.
//  - States:
//    - IDLE: accept on req_valid&&req_ready at cycle T; latch op/addr/data/tag.
//      - Legal+aligned -> REQ. Misaligned (H: addr[0]!=0, W: addr[1:0]!=0) or unknown op -> DONE, no memreq.
//    - REQ: mem_request_enable=1 for exactly cycle T+1 -> WAIT.
//      - mem_request fields stay stable from T+1 until the response arrives.
//    - WAIT: on mem_response_enable capture data -> DONE. Enable pulses seen in IDLE/REQ/DONE are ignored.
//    - DONE: done_valid=1 for one cycle with data/tag/exc/cause -> IDLE (req_ready=1 the next cycle).
//  - Latency:
//    - Exception op: done_valid at T+1.
//    - Memory op: done_valid 1 cycle after the response pulse (minimum T+3).
//  - mem_request.addr = {addr[31:2],2'b00}. mode = MEMREQ_READ for loads, MEMREQ_WRITE for stores.
//  - Store lanes:
//    - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0]
//    - SH: wdata={2{d[15:0]}}, wstrb=4'b0011<<addr[1:0]
//    - SW: wdata=d, wstrb=4'b1111
//  - Load extract: byte at data>>(8*addr[1:0]), half at data>>(16*addr[1]).
//    - LB/LH sign-extend. LBU/LHU zero-extend. LW passes through.
//  - Loads drive wstrb=0 and wdata=0.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//   - 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
//   - At TIMEOUT_CYCLES without a response -> DONE with done_exc=1, cause 5 (load) or 7 (store), done_data=0.
//   - A late response is ignored.
//  LSU_TIMEOUT_EN undefined: WAIT holds indefinitely; no counter logic is synthesised.
// STRUCTURE
//  def.sv package:
//   - lsu_op_t enum.
//   - Cause constants CAUSE_ILLEGAL=2, CAUSE_LD_MISALIGN=4, CAUSE_LD_FAULT=5, CAUSE_ST_MISALIGN=6, CAUSE_ST_FAULT=7.
//   - Existing memreq/memresp/MEMREQ_* unchanged.
//  Sub-module lsu_align (combinational):
//   - Store path: op, addr[1:0], wdata -> lane wdata, wstrb, misaligned.
//   - Load path: op, addr[1:0], rdata -> extended result.
//  FSM, latches and watchdog stay in load_store_unit.
// TESTING
//  - SB addr=0x103 d=0x000000AB -> one req: addr 0x100, wstrb 0x8, wdata 0xABABABAB; resp -> done, data 0.
//  - LH addr=0x202, resp 0x8001_1234 -> req addr 0x200 read, wstrb 0; done_data 0xFFFF8001.
//    - Same with LHU -> done_data 0x00008001.
//  - LW addr=0x301 -> no mem_request_enable; done_valid at T+1, exc=1, cause=4. SH addr=0x5 -> cause=6.
//  - Response pulses in IDLE, and rst asserted in WAIT followed by a late response -> no done_valid, req_ready=1.
//  - Back-to-back: req_valid held high with two ops -> second accepted the cycle after first done_valid, tags in order.
//  - LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response to SW -> done cause 7 after 8 WAIT cycles; late response ignored.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: op encodings, exception causes and MMU port types for the load/store unit
package load_store_unit_pkg;
    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } lsu_op_t;
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;
    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;
    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } memreq;
    typedef struct packed {
        logic [31:0] data;
    } memresp;
    function automatic logic is_store_op(input lsu_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
endpackage

// File: rtl/load_store_unit_align.sv
// load_store_unit_align: combinational store lane steering and load extraction/extension
// Ports:
//   st_op/st_addr/st_data -> lane_wdata, lane_wstrb, is_store, illegal, misaligned
//   ld_op/ld_addr/rdata   -> ld_result (sign/zero-extended)
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  lsu_op_t     st_op,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_data,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_wstrb,
    output logic        is_store,
    output logic        illegal,
    output logic        misaligned,
    input  lsu_op_t     ld_op,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] rdata,
    output logic [31:0] ld_result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        is_store   = is_store_op(st_op);
        illegal    = !(is_store || st_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
        misaligned = st_op inside {OP_LH, OP_LHU, OP_SH} ? st_addr[0] :
                     st_op inside {OP_LW, OP_SW} ? |st_addr : 1'b0;
        lane_wdata = st_op == OP_SB ? {4{st_data[7:0]}} :
                     st_op == OP_SH ? {2{st_data[15:0]}} :
                     st_op == OP_SW ? st_data : 32'h0;
        lane_wstrb = st_op == OP_SB ? 4'b0001 << st_addr :
                     st_op == OP_SH ? 4'b0011 << st_addr :
                     st_op == OP_SW ? 4'b1111 : 4'b0000;
        b = rdata[{ld_addr, 3'b000} +: 8];
        h = rdata[{ld_addr[1], 4'b0000} +: 16];
        ld_result = ld_op == OP_LB  ? {{24{b[7]}}, b} :
                    ld_op == OP_LH  ? {{16{h[15]}}, h} :
                    ld_op == OP_LBU ? {24'h0, b} :
                    ld_op == OP_LHU ? {16'h0, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage issuing one word-aligned MMU request per load/store
// Optional: define LSU_TIMEOUT_EN to add a response watchdog (TIMEOUT_CYCLES) raising access faults.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/ready/op/addr/wdata/tag operation from execute
//   mem_request_enable, mem_request   request pulse and payload to MMU
//   mem_response_enable, mem_response completion pulse and read data from MMU
//   done_valid/data/tag/exc/cause     completion to writeback
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TAG_W = 5
`ifdef LSU_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  lsu_op_t          req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_request_enable,
    output memreq            mem_request,
    input  logic             mem_response_enable,
    input  memresp           mem_response,
    output logic             done_valid,
    output logic [31:0]      done_data,
    output logic [TAG_W-1:0] done_tag,
    output logic             done_exc,
    output logic [3:0]       done_cause
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state;
    lsu_op_t     op_q;
    logic [1:0]  addr_q;
    logic [31:0] lane_wdata, ld_result;
    logic [3:0]  lane_wstrb;
    logic        is_store, illegal, misaligned;
`ifdef LSU_TIMEOUT_EN
    logic [31:0] cnt;
`endif
    load_store_unit_align u_align (
        .st_op      (req_op),
        .st_addr    (req_addr[1:0]),
        .st_data    (req_wdata),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .is_store   (is_store),
        .illegal    (illegal),
        .misaligned (misaligned),
        .ld_op      (op_q),
        .ld_addr    (addr_q),
        .rdata      (mem_response.data),
        .ld_result  (ld_result)
    );
    // The request payload is registered at accept so it is stable from the pulse until the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            req_ready          <= 1'b1;
            mem_request_enable <= 1'b0;
            mem_request        <= '0;
            done_valid         <= 1'b0;
            done_data          <= '0;
            done_tag           <= '0;
            done_exc           <= 1'b0;
            done_cause         <= '0;
            op_q               <= OP_LB;
            addr_q             <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt                <= '0;
`endif
        end else begin
            mem_request_enable <= 1'b0;
            done_valid         <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    op_q      <= req_op;
                    addr_q    <= req_addr[1:0];
                    done_tag  <= req_tag;
                    done_data <= '0;
                    if (illegal || misaligned) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        done_exc   <= 1'b1;
                        done_cause <= illegal ? CAUSE_ILLEGAL : is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                    end else begin
                        state              <= REQ;
                        mem_request_enable <= 1'b1;
                        mem_request        <= '{mode: is_store ? MEMREQ_WRITE : MEMREQ_READ,
                                                addr: {req_addr[31:2], 2'b00},
                                                wstrb: lane_wstrb, wdata: lane_wdata};
                        done_exc           <= 1'b0;
                        done_cause         <= '0;
                    end
                end
                REQ: begin
                    state <= WAIT;
`ifdef LSU_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT: if (mem_response_enable) begin
                    state      <= DONE;
                    done_valid <= 1'b1;
                    done_data  <= is_store_op(op_q) ? 32'h0 : ld_result;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state      <= DONE;
                    done_valid <= 1'b1;
                    done_exc   <= 1'b1;
                    done_cause <= is_store_op(op_q) ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                end else begin
                    cnt <= cnt + 32'd1;
                end
`endif
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
    import load_store_unit_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    lsu_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        mem_request_enable;
    memreq       mem_request;
    logic        mem_response_enable;
    memresp      mem_response;
    logic        done_valid;
    logic [31:0] done_data;
    logic [4:0]  done_tag;
    logic        done_exc;
    logic [3:0]  done_cause;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TAG_W(5)
`ifdef LSU_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_tag             (req_tag),
        .mem_request_enable  (mem_request_enable),
        .mem_request         (mem_request),
        .mem_response_enable (mem_response_enable),
        .mem_response        (mem_response),
        .done_valid          (done_valid),
        .done_data           (done_data),
        .done_tag            (done_tag),
        .done_exc            (done_exc),
        .done_cause          (done_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input lsu_op_t op, input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        req_tag   = t;
        step();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        mem_response_enable = 1'b1;
        mem_response.data   = d;
        step();
        mem_response_enable = 1'b0;
    endtask

    task automatic mem_op(input string nm, input lsu_op_t op, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] t, input logic [31:0] rd,
                          input logic [31:0] exp_addr, input logic exp_mode, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data);
        issue(op, a, d, t);
        chk({nm, "_req_en"}, mem_request_enable, 1);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_addr"}, mem_request.addr, exp_addr);
        chk({nm, "_mode"}, mem_request.mode, exp_mode);
        chk({nm, "_wstrb"}, mem_request.wstrb, exp_strb);
        chk({nm, "_wdata"}, mem_request.wdata, exp_wdata);
        step();
        chk({nm, "_req_pulse"}, mem_request_enable, 0);
        chk({nm, "_hold_addr"}, mem_request.addr, exp_addr);
        respond(rd);
        chk({nm, "_done"}, done_valid, 1);
        chk({nm, "_data"}, done_data, exp_data);
        chk({nm, "_tag"}, done_tag, t);
        chk({nm, "_exc"}, done_exc, 0);
        step();
        chk({nm, "_done_pulse"}, done_valid, 0);
        chk({nm, "_ready"}, req_ready, 1);
    endtask

    task automatic exc_op(input string nm, input lsu_op_t op, input logic [31:0] a, input logic [4:0] t,
                          input logic [3:0] exp_cause);
        issue(op, a, 32'hFFFF_FFFF, t);
        chk({nm, "_no_req"}, mem_request_enable, 0);
        chk({nm, "_done"}, done_valid, 1);
        chk({nm, "_exc"}, done_exc, 1);
        chk({nm, "_cause"}, done_cause, exp_cause);
        chk({nm, "_data"}, done_data, 0);
        chk({nm, "_tag"}, done_tag, t);
        step();
        chk({nm, "_ready"}, req_ready, 1);
        chk({nm, "_done_pulse"}, done_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = OP_LB;
        req_addr = '0;
        req_wdata = '0;
        req_tag = '0;
        mem_response_enable = 1'b0;
        mem_response = '0;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_req_en", mem_request_enable, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_exc", done_exc, 0);
        chk("rst_addr", mem_request.addr, 0);
        rst = 1'b0;
        step();

        mem_op("sb", OP_SB, 32'h103, 32'h0000_00AB, 5'd3, 32'h0, 32'h100, MEMREQ_WRITE, 4'h8, 32'hABAB_ABAB, 32'h0);
        mem_op("lh", OP_LH, 32'h202, 32'h0, 5'd7, 32'h8001_1234, 32'h200, MEMREQ_READ, 4'h0, 32'h0, 32'hFFFF_8001);
        mem_op("lhu", OP_LHU, 32'h202, 32'h0, 5'd8, 32'h8001_1234, 32'h200, MEMREQ_READ, 4'h0, 32'h0, 32'h0000_8001);
        mem_op("lb", OP_LB, 32'h401, 32'h0, 5'd9, 32'h1234_8056, 32'h400, MEMREQ_READ, 4'h0, 32'h0, 32'hFFFF_FF80);
        mem_op("lbu", OP_LBU, 32'h403, 32'h0, 5'd10, 32'hA512_3456, 32'h400, MEMREQ_READ, 4'h0, 32'h0, 32'h0000_00A5);
        mem_op("lw", OP_LW, 32'h500, 32'h0, 5'd11, 32'hDEAD_BEEF, 32'h500, MEMREQ_READ, 4'h0, 32'h0, 32'hDEAD_BEEF);
        mem_op("sh", OP_SH, 32'h12, 32'hFFFF_1234, 5'd12, 32'h0, 32'h10, MEMREQ_WRITE, 4'hC, 32'h1234_1234, 32'h0);
        mem_op("sw", OP_SW, 32'h20, 32'hCAFE_F00D, 5'd13, 32'h0, 32'h20, MEMREQ_WRITE, 4'hF, 32'hCAFE_F00D, 32'h0);

        exc_op("lw_mis", OP_LW, 32'h301, 5'd14, CAUSE_LD_MISALIGN);
        exc_op("sh_mis", OP_SH, 32'h5, 5'd15, CAUSE_ST_MISALIGN);
        exc_op("illegal", lsu_op_t'(4'd3), 32'h0, 5'd16, CAUSE_ILLEGAL);

        respond(32'h1111_1111);
        chk("idle_resp_done", done_valid, 0);
        chk("idle_resp_ready", req_ready, 1);
        chk("idle_resp_req", mem_request_enable, 0);

        issue(OP_LW, 32'h40, 32'h0, 5'd17);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait_ready", req_ready, 1);
        respond(32'h2222_2222);
        chk("late_resp_done", done_valid, 0);
        step();
        chk("late_resp_done2", done_valid, 0);
        chk("late_resp_ready", req_ready, 1);

        req_valid = 1'b1;
        req_op = OP_LW;
        req_addr = 32'h60;
        req_tag = 5'd1;
        step();
        req_op = OP_LBU;
        req_addr = 32'h63;
        req_tag = 5'd2;
        chk("b2b_req1", mem_request.addr, 32'h60);
        step();
        respond(32'hA500_0000);
        chk("b2b_done1", done_valid, 1);
        chk("b2b_tag1", done_tag, 1);
        chk("b2b_data1", done_data, 32'hA500_0000);
        chk("b2b_busy", req_ready, 0);
        step();
        chk("b2b_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("b2b_req2_en", mem_request_enable, 1);
        chk("b2b_req2_addr", mem_request.addr, 32'h60);
        step();
        respond(32'hA500_0000);
        chk("b2b_done2", done_valid, 1);
        chk("b2b_tag2", done_tag, 2);
        chk("b2b_data2", done_data, 32'h0000_00A5);
        step();

`ifdef LSU_TIMEOUT_EN
        issue(OP_SW, 32'h80, 32'h1234_5678, 5'd20);
        for (int i = 0; i < 8; i++) step();
        chk("to_early", done_valid, 0);
        step();
        chk("to_done", done_valid, 1);
        chk("to_exc", done_exc, 1);
        chk("to_cause", done_cause, CAUSE_ST_FAULT);
        chk("to_data", done_data, 0);
        step();
        respond(32'h3333_3333);
        chk("to_late_done", done_valid, 0);
        chk("to_late_ready", req_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
